// File: rtl/avalon_mm_register_bridge.sv
// Avalon-MM slave to peripheral register bridge.
// Accepts one command per cycle, delays it by LATENCY-1 register stages, then
// issues a one-hot read/write strobe toward the peripheral register file and
// returns registered read data one cycle later. Reads are throttled so that
// no more than MAX_PENDING are in flight.
// Optional build macro: REG_BRIDGE_ERR_RESP_EN. When it is defined, out-of-range
// accesses return SLVERR and set a sticky err_seen flag. When it is undefined,
// response is always OKAY.
module avalon_mm_register_bridge #(
  parameter int REGS        = 4,
  parameter int DATAWIDTH   = 32,
  parameter int LATENCY     = 2,
  parameter int MAX_PENDING = 2,
  parameter int ADDRWIDTH   = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDRWIDTH-1:0]      address,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATAWIDTH-1:0]      writedata,
  input  logic [DATAWIDTH/8-1:0]    byteenable,
  output logic                      waitrequest,
  output logic [DATAWIDTH-1:0]      readdata,
  output logic                      readdatavalid,
  output logic [1:0]                response,
  output logic [REGS-1:0]           reg_write_en,
  output logic [REGS-1:0]           reg_read_en,
  output logic [DATAWIDTH-1:0]      reg_wdata,
  output logic [DATAWIDTH/8-1:0]    reg_byteen,
  input  logic [REGS*DATAWIDTH-1:0] reg_rdata
);

  localparam int BE_W   = DATAWIDTH / 8;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [ADDRWIDTH:0]  REGS_LIM = (ADDRWIDTH + 1)'(REGS);
  localparam logic [PEND_W-1:0]   PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

  state_t              state_q;
  logic [PEND_W-1:0]   pending_q;
  logic                acc_rd, acc_wr;

  // Command as it appears in the strobe cycle (C+LATENCY-1)
  logic                st_rd, st_wr;
  logic [ADDRWIDTH-1:0] st_addr;
  logic [DATAWIDTH-1:0] st_wdata;
  logic [BE_W-1:0]     st_be;
  logic                st_in_range;
  logic [DATAWIDTH-1:0] wdata_masked;
  logic [DATAWIDTH-1:0] rd_mux;

  logic                readdatavalid_q;
  logic [DATAWIDTH-1:0] readdata_q;

  // Power-up sequencing: hold off the bus for the reset cycle and one INIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // A simultaneous read+write is treated as a write, so it is never stalled
  assign waitrequest = (state_q != ST_RUN) | (read & ~write & (pending_q == PEND_MAX));
  assign acc_wr      = write & ~waitrequest;
  assign acc_rd      = read & ~write & ~waitrequest;

  generate
    if (LATENCY == 1) begin : g_comb
      assign st_rd    = acc_rd;
      assign st_wr    = acc_wr;
      assign st_addr  = address;
      assign st_wdata = writedata;
      assign st_be    = byteenable;
    end else begin : g_pipe
      logic [LATENCY-2:0]   rd_q, wr_q;
      logic [ADDRWIDTH-1:0] addr_q  [LATENCY-1];
      logic [DATAWIDTH-1:0] wdata_q [LATENCY-1];
      logic [BE_W-1:0]      be_q    [LATENCY-1];

      // Delay line for accepted commands; reset discards anything in flight
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_q <= '0;
          wr_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            be_q[i]    <= '0;
          end
        end else begin
          rd_q[0]    <= acc_rd;
          wr_q[0]    <= acc_wr;
          addr_q[0]  <= address;
          wdata_q[0] <= writedata;
          be_q[0]    <= byteenable;
          for (int i = 1; i < LATENCY - 1; i++) begin
            rd_q[i]    <= rd_q[i-1];
            wr_q[i]    <= wr_q[i-1];
            addr_q[i]  <= addr_q[i-1];
            wdata_q[i] <= wdata_q[i-1];
            be_q[i]    <= be_q[i-1];
          end
        end
      end

      assign st_rd    = rd_q[LATENCY-2];
      assign st_wr    = wr_q[LATENCY-2];
      assign st_addr  = addr_q[LATENCY-2];
      assign st_wdata = wdata_q[LATENCY-2];
      assign st_be    = be_q[LATENCY-2];
    end
  endgenerate

  assign st_in_range = ({1'b0, st_addr} < REGS_LIM);

  genvar gi;
  generate
    for (gi = 0; gi < REGS; gi++) begin : g_strobe
      assign reg_write_en[gi] = st_wr & (st_addr == ADDRWIDTH'(gi));
      assign reg_read_en[gi]  = st_rd & (st_addr == ADDRWIDTH'(gi));
    end
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign wdata_masked[gi*8 +: 8] = st_wdata[gi*8 +: 8] & {8{st_be[gi]}};
    end
  endgenerate

  // Write data and lanes are only presented alongside a real write strobe
  assign reg_wdata  = (st_wr & st_in_range) ? wdata_masked : '0;
  assign reg_byteen = (st_wr & st_in_range) ? st_be : '0;

  // Select the strobed register word; out-of-range selects nothing and yields 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < REGS; i++) begin
      if (reg_read_en[i]) rd_mux = rd_mux | reg_rdata[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Outstanding-read count: +1 on read acceptance, -1 on each return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      case ({acc_rd, readdatavalid_q})
        2'b10:   pending_q <= pending_q + PEND_W'(1);
        2'b01:   if (pending_q != '0) pending_q <= pending_q - PEND_W'(1);
        default: pending_q <= pending_q;
      endcase
    end
  end

`ifdef REG_BRIDGE_ERR_RESP_EN
  logic       err_seen_q;
  logic [1:0] response_q;

  // Sticky record of any out-of-range access, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_seen_q <= 1'b0;
    end else if ((st_rd | st_wr) & ~st_in_range) begin
      err_seen_q <= 1'b1;
    end
  end

  // Read return with SLVERR for out-of-range or after any earlier error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
      response_q      <= 2'b00;
    end else begin
      readdatavalid_q <= st_rd;
      if (st_rd) begin
        readdata_q <= st_in_range ? rd_mux : '0;
        response_q <= (~st_in_range | err_seen_q) ? 2'b10 : 2'b00;
      end
    end
  end

  assign response = response_q;
`else
  // Read return; readdata holds its last value between returns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
    end else begin
      readdatavalid_q <= st_rd;
      if (st_rd) readdata_q <= st_in_range ? rd_mux : '0;
    end
  end

  assign response = 2'b00;
`endif

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: doc/avalon_mm_register_bridge.md
Name: avalon_mm_register_bridge

Overview:
Parametrised Avalon-MM slave to peripheral-register bridge, generalising the single-width register adapter.
- Configurable data width, register count and pipeline latency.
- Byte enables, waitrequest back-pressure with a bounded outstanding-read count, and out-of-range address detection.
- Sits between the system interconnect and a peripheral's register file; drives one-hot per-register read/write strobes.

Parameters:
REGS, 4, number of peripheral registers (>=1)
DATAWIDTH, 32, register/bus data width (multiple of 8)
LATENCY, 2, cycles from command acceptance to readdatavalid (1..8)
MAX_PENDING, 2, maximum reads in flight before waitrequest asserts (1..LATENCY)
ADDRWIDTH, max(1,$clog2(REGS)), word address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
address  in  ADDRWIDTH  word address
read  in  1  read request
write  in  1  write request
writedata  in  DATAWIDTH  write data
byteenable  in  DATAWIDTH/8  byte lane enables
waitrequest  out  1  command not accepted this cycle
readdata  out  DATAWIDTH  read data
readdatavalid  out  1  readdata valid strobe
response  out  2  00 OKAY, 10 SLVERR
reg_write_en  out  REGS  one-hot write strobe
reg_read_en  out  REGS  one-hot read strobe
reg_wdata  out  DATAWIDTH  byte-masked write data
reg_byteen  out  DATAWIDTH/8  byte enables for the strobed write
reg_rdata  in  REGS*DATAWIDTH  concatenated register contents; register i at bits [i*DATAWIDTH +: DATAWIDTH]

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Reset values: waitrequest=1, readdata=0, readdatavalid=0, response=00, all strobes=0, reg_wdata=0, reg_byteen=0, pending=0.
- Init state machine: RESET -> INIT (one cycle after reset deasserts, waitrequest=1) -> RUN.
- Acceptance: command accepted in cycle C when (read|write) && !waitrequest.
- Back-pressure in RUN: waitrequest = read && (pending == MAX_PENDING). Writes are never stalled in RUN.
- Command pipeline: LATENCY-1 register stages carry valid/rd/wr/address/writedata/byteenable. With LATENCY=1 the stage-0 path is combinational.
- Strobes: issued in cycle C+LATENCY-1 as one-hot on reg_write_en/reg_read_en[address], for exactly one cycle per accepted command.
  - reg_wdata = writedata with disabled byte lanes forced to 0.
  - reg_byteen = byteenable.
- Read return: reg_rdata[address] is sampled at the end of cycle C+LATENCY-1. readdata is registered and readdatavalid=1 in cycle C+LATENCY. Otherwise readdata holds its last value and readdatavalid=0.
- Out-of-range address (address >= REGS):
  - No strobe is issued.
  - A read still returns readdatavalid, with readdata=0 and response=10.
  - A write is silently dropped; the error is recorded in the sticky flag (see Optional Feature).
- pending counter:
  - +1 on read acceptance, -1 on readdatavalid, net 0 when both occur in the same cycle.
  - Never exceeds MAX_PENDING and never underflows.
- Simultaneous read and write in one cycle: the write is accepted and the read is discarded (no readdatavalid). waitrequest is evaluated as for a write.
- Back-to-back commands: one command per cycle is accepted, subject to waitrequest.
- Reset mid-operation: all in-flight commands are discarded, with no strobes or readdatavalid afterwards. The block re-enters INIT.

Optional Feature:
Macro REG_BRIDGE_ERR_RESP_EN.
- Defined: response is driven as above. An additional sticky flag err_seen is set by any out-of-range access.
  - err_seen is cleared only by reset.
  - While set, response is ORed onto every subsequent read return as 10.
- Undefined: response is tied to 00 and no sticky flag exists. Out-of-range reads return readdata=0 with response 00.

Test Plan:
1. Reset release, LATENCY=2 -> waitrequest=1 for the reset cycle and the INIT cycle, then 0. All outputs are at their reset values.
2. Write addr 2, writedata 0xDEADBEEF, byteenable 4'b0101 -> reg_write_en=4'b0100 for one cycle at C+1, reg_wdata=0x00AD00EF, reg_byteen=4'b0101.
3. Read addr 1 with reg_rdata word1=0x12345678 -> reg_read_en=4'b0010 at C+1, readdatavalid=1 and readdata=0x12345678 at C+2, response 00.
4. Three back-to-back reads, MAX_PENDING=2, LATENCY=2 -> third read sees waitrequest=1 for one cycle and is accepted on the next cycle. Exactly three readdatavalid pulses, in order.
5. Read addr 5 with REGS=4 (ADDRWIDTH=3) -> no strobe, readdata=0, response=10 with the macro defined, 00 without it.
6. Assert reset with two reads in flight -> no readdatavalid pulses and no strobes afterwards, pending=0, and a normal read succeeds after INIT.
